// File: rtl/snitch_icache_refill_writer.sv
// Miss handler behind the serial L1 lookup: forwards hits, merges misses per line, refills and writes lines back.
// Victim selection: define SNITCH_ICACHE_REFILL_LFSR_EN for an 8-bit LFSR, otherwise a round-robin counter.
module snitch_icache_refill_writer #(
  parameter int FETCH_AW      = 32,
  parameter int LINE_WIDTH    = 128,
  parameter int LINE_ALIGN    = 4,
  parameter int COUNT_ALIGN   = 6,
  parameter int WAY_COUNT     = 4,
  parameter int ID_WIDTH      = 4,
  parameter int PENDING_COUNT = 2,
  parameter int SET_ALIGN     = $clog2(WAY_COUNT),
  parameter int TAG_WIDTH     = FETCH_AW - LINE_ALIGN - COUNT_ALIGN,
  parameter int PA            = (PENDING_COUNT > 1) ? $clog2(PENDING_COUNT) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [FETCH_AW-1:0]    in_addr_i,
  input  logic [ID_WIDTH-1:0]    in_id_i,
  input  logic                   in_hit_i,
  input  logic                   in_error_i,
  input  logic [LINE_WIDTH-1:0]  in_data_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [FETCH_AW-1:0]    rsp_addr_o,
  output logic [ID_WIDTH-1:0]    rsp_id_o,
  output logic [LINE_WIDTH-1:0]  rsp_data_o,
  output logic                   rsp_error_o,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [FETCH_AW-1:0]    refill_req_addr_o,
  output logic [PA-1:0]          refill_req_id_o,
  output logic                   refill_req_valid_o,
  input  logic                   refill_req_ready_i,
  input  logic [LINE_WIDTH-1:0]  refill_rsp_data_i,
  input  logic                   refill_rsp_error_i,
  input  logic [PA-1:0]          refill_rsp_id_i,
  input  logic                   refill_rsp_valid_i,
  output logic                   refill_rsp_ready_o,
  output logic [COUNT_ALIGN-1:0] write_addr_o,
  output logic [SET_ALIGN-1:0]   write_set_o,
  output logic [TAG_WIDTH-1:0]   write_tag_o,
  output logic [LINE_WIDTH-1:0]  write_data_o,
  output logic                   write_error_o,
  output logic                   write_valid_o,
  input  logic                   write_ready_i
);

  typedef enum logic [1:0] {IDLE, WRITE, RESP} state_e;

  state_e                  state_q;
  logic [PENDING_COUNT-1:0] pend_valid_q;
  logic [FETCH_AW-1:0]     pend_line_q [PENDING_COUNT];
  logic [ID_WIDTH-1:0]     pend_mask_q [PENDING_COUNT];

  logic                    req_valid_q;
  logic [FETCH_AW-1:0]     req_addr_q;
  logic [PA-1:0]           req_idx_q;

  logic [PA-1:0]           cur_idx_q;
  logic [FETCH_AW-1:0]     cur_line_q;
  logic [LINE_WIDTH-1:0]   cur_data_q;
  logic                    cur_error_q;
  logic [SET_ALIGN-1:0]    cur_set_q;
  logic [SET_ALIGN-1:0]    victim;

  logic [FETCH_AW-1:0]     miss_line;
  logic                    match_any, free_any;
  logic [PA-1:0]           match_idx, free_idx;
  logic                    in_resp, match_busy, can_alloc;
  logic                    miss_merge, miss_alloc, hit_fwd;

  assign miss_line = {in_addr_i[FETCH_AW-1:LINE_ALIGN], {LINE_ALIGN{1'b0}}};

  // Scan downwards so the lowest free index wins.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    for (int i = PENDING_COUNT - 1; i >= 0; i--) begin
      if (pend_valid_q[i] && (pend_line_q[i] == miss_line)) begin
        match_any = 1'b1;
        match_idx = PA'(i);
      end
      if (!pend_valid_q[i]) begin
        free_any = 1'b1;
        free_idx = PA'(i);
      end
    end
  end

  assign in_resp    = (state_q == RESP);
  // The entry being answered must not grow its mask after the id was presented.
  assign match_busy = match_any && in_resp && (match_idx == cur_idx_q);
  assign can_alloc  = free_any && (!req_valid_q || refill_req_ready_i);

  always_comb begin
    if (in_hit_i)       in_ready_o = rsp_ready_i && !in_resp;
    else if (match_any) in_ready_o = !match_busy;
    else                in_ready_o = can_alloc;
  end

  assign miss_merge = in_valid_i && !in_hit_i && match_any && !match_busy;
  assign miss_alloc = in_valid_i && !in_hit_i && !match_any && can_alloc;
  assign hit_fwd    = in_valid_i && in_hit_i && !in_resp;

  always_comb begin
    rsp_valid_o = 1'b0;
    rsp_addr_o  = '0;
    rsp_id_o    = '0;
    rsp_data_o  = '0;
    rsp_error_o = 1'b0;
    if (in_resp) begin
      rsp_valid_o = 1'b1;
      rsp_addr_o  = cur_line_q;
      rsp_id_o    = pend_mask_q[cur_idx_q];
      rsp_data_o  = cur_data_q;
      rsp_error_o = cur_error_q;
    end else if (hit_fwd) begin
      rsp_valid_o = 1'b1;
      rsp_addr_o  = in_addr_i;
      rsp_id_o    = in_id_i;
      rsp_data_o  = in_data_i;
      rsp_error_o = in_error_i;
    end
  end

  assign refill_req_valid_o = req_valid_q;
  assign refill_req_addr_o  = req_addr_q;
  assign refill_req_id_o    = req_idx_q;
  assign refill_rsp_ready_o = (state_q == IDLE);

  assign write_valid_o = (state_q == WRITE);
  assign write_addr_o  = cur_line_q[LINE_ALIGN +: COUNT_ALIGN];
  assign write_tag_o   = cur_line_q[FETCH_AW-1:LINE_ALIGN+COUNT_ALIGN];
  assign write_data_o  = cur_data_q;
  assign write_error_o = cur_error_q;
  assign write_set_o   = cur_set_q;

`ifdef SNITCH_ICACHE_REFILL_LFSR_EN
  logic [7:0] lfsr_q;
  // Galois form of x^8+x^6+x^5+x^4+1, free-running.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= 8'hA5;
    else       lfsr_q <= {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
  end
  assign victim = lfsr_q[SET_ALIGN-1:0];
`else
  logic [SET_ALIGN-1:0] rr_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else if (write_valid_o && write_ready_i) begin
      rr_q <= (rr_q == SET_ALIGN'(WAY_COUNT - 1)) ? '0 : rr_q + 1'b1;
    end
  end
  assign victim = rr_q;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      pend_valid_q <= '0;
      for (int i = 0; i < PENDING_COUNT; i++) begin
        pend_line_q[i] <= '0;
        pend_mask_q[i] <= '0;
      end
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_idx_q   <= '0;
      cur_idx_q   <= '0;
      cur_line_q  <= '0;
      cur_data_q  <= '0;
      cur_error_q <= 1'b0;
      cur_set_q   <= '0;
    end else begin
      if (req_valid_q && refill_req_ready_i) req_valid_q <= 1'b0;

      // Return path first, so a free is ordered before any allocation below.
      case (state_q)
        IDLE: begin
          if (refill_rsp_valid_i && pend_valid_q[refill_rsp_id_i]) begin
            cur_idx_q   <= refill_rsp_id_i;
            cur_line_q  <= pend_line_q[refill_rsp_id_i];
            cur_data_q  <= refill_rsp_data_i;
            cur_error_q <= refill_rsp_error_i;
            cur_set_q   <= victim;
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          if (write_ready_i) state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            pend_valid_q[cur_idx_q] <= 1'b0;
            state_q                 <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (miss_alloc) begin
        req_valid_q             <= 1'b1;
        req_addr_q              <= miss_line;
        req_idx_q               <= free_idx;
        pend_valid_q[free_idx]  <= 1'b1;
        pend_line_q[free_idx]   <= miss_line;
        pend_mask_q[free_idx]   <= in_id_i;
      end
      if (miss_merge) begin
        pend_mask_q[match_idx] <= pend_mask_q[match_idx] | in_id_i;
      end
    end
  end

endmodule
